// File: rtl/klein64_enc_if.sv
// Request/response bundle for the KLEIN-64 encryption core.
// The master side issues a block; the slave side returns the ciphertext.
interface klein64_enc_if;
  logic        start;
  logic [63:0] key_in;
  logic [63:0] pt_in;
  logic        busy;
  logic        done;
  logic [63:0] ct_out;

  modport master (
    output start,
    output key_in,
    output pt_in,
    input  busy,
    input  done,
    input  ct_out
  );

  modport slave (
    input  start,
    input  key_in,
    input  pt_in,
    output busy,
    output done,
    output ct_out
  );
endinterface

// File: rtl/klein64_enc_core.sv
// Iterative KLEIN-64 encryption core: one full round per clock.
// The round key schedule runs alongside the data path, one step per round.
module klein64_enc_core #(
  parameter int unsigned ROUNDS = 12
) (
  input logic          clk,
  input logic          rst_n,
  klein64_enc_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [3:0] LastRnd = 4'(ROUNDS);

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'h7;
      4'h1: y = 4'h4;
      4'h2: y = 4'hA;
      4'h3: y = 4'h9;
      4'h4: y = 4'h1;
      4'h5: y = 4'hF;
      4'h6: y = 4'hB;
      4'h7: y = 4'h0;
      4'h8: y = 4'hC;
      4'h9: y = 4'h3;
      4'hA: y = 4'h2;
      4'hB: y = 4'h6;
      4'hC: y = 4'h8;
      4'hD: y = 4'hE;
      4'hE: y = 4'hD;
      default: y = 4'h5;
    endcase
    return y;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // AES MixColumns on one 4-byte tuple, byte 0 in the top bits.
  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] s0, s1, s2, s3;
    s0 = w[31:24];
    s1 = w[23:16];
    s2 = w[15:8];
    s3 = w[7:0];
    return {xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
            s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
            s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
            xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)};
  endfunction

  state_e      st_q, st_d;
  logic [63:0] data_q, data_d;
  logic [63:0] rkey_q, rkey_d;
  logic [3:0]  rnd_q, rnd_d;
  logic [63:0] ct_q, ct_d;

  // Data path: AddRoundKey, SubNibbles, RotateNibbles, MixNibbles.
  logic [63:0] ark, sub, rot, round_out;

  assign ark = data_q ^ rkey_q;

  for (genvar n = 0; n < 16; n++) begin : g_sub
    assign sub[4*n +: 4] = sbox(ark[4*n +: 4]);
  end

  assign rot       = {sub[47:0], sub[63:48]};
  assign round_out = {mix_col(rot[63:32]), mix_col(rot[31:0])};

  // Key schedule step from the current round key and round number.
  logic [31:0] ka_rot, kb_rot, kb_mix;
  logic [15:0] kb_sub;
  logic [63:0] next_key;

  assign ka_rot = {rkey_q[55:32], rkey_q[63:56]};
  assign kb_rot = {rkey_q[23:0], rkey_q[31:24]};
  assign kb_mix = ka_rot ^ kb_rot;

  for (genvar n = 0; n < 4; n++) begin : g_ksub
    assign kb_sub[4*n +: 4] = sbox(kb_mix[8 + 4*n +: 4]);
  end

  assign next_key = {kb_rot[31:16], kb_rot[15:8] ^ {4'h0, rnd_q}, kb_rot[7:0],
                     kb_mix[31:24], kb_sub, kb_mix[7:0]};

  always_comb begin
    st_d   = st_q;
    data_d = data_q;
    rkey_d = rkey_q;
    rnd_d  = rnd_q;
    ct_d   = ct_q;
    unique case (st_q)
      StIdle: begin
        if (bus.start) begin
          data_d = bus.pt_in;
          rkey_d = bus.key_in;
          rnd_d  = 4'd1;
          st_d   = StRun;
        end
      end
      StRun: begin
        data_d = round_out;
        rkey_d = next_key;
        rnd_d  = rnd_q + 4'd1;
        if (rnd_q == LastRnd) begin
          // Final whitening with sk_{ROUNDS+1}.
          ct_d = round_out ^ next_key;
          st_d = StDone;
        end
      end
      StDone: begin
        rnd_d = 4'd0;
        st_d  = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= StIdle;
      data_q <= '0;
      rkey_q <= '0;
      rnd_q  <= '0;
      ct_q   <= '0;
    end else begin
      st_q   <= st_d;
      data_q <= data_d;
      rkey_q <= rkey_d;
      rnd_q  <= rnd_d;
      ct_q   <= ct_d;
    end
  end

  assign bus.busy   = (st_q != StIdle);
  assign bus.done   = (st_q == StDone);
  assign bus.ct_out = ct_q;

endmodule

// File: tb/tb_klein64_enc_core.sv
// Scoreboard bench for the KLEIN-64 encryption core using the published test vectors.
module tb_klein64_enc_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  klein64_enc_if bus ();

  klein64_enc_core #(.ROUNDS(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [63:0] ct;
    logic [31:0] due;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] cyc = '0;
  logic [63:0] hold_ct = '0;

  localparam logic [63:0] K1 = 64'h0000000000000000, P1 = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] C1 = 64'hCDC0B51F14722BBE;
  localparam logic [63:0] K2 = 64'hFFFFFFFFFFFFFFFF, P2 = 64'h0000000000000000;
  localparam logic [63:0] C2 = 64'h6456764E8602E154;
  localparam logic [63:0] K3 = 64'h1234567890ABCDEF, P3 = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] C3 = 64'h592356C4997176C8;
  localparam logic [63:0] K4 = 64'h0000000000000000, P4 = 64'h1234567890ABCDEF;
  localparam logic [63:0] C4 = 64'h629F9D6DFF95800E;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin : mon
    logic r;
    exp_t e;
    r = rst_n;
    cyc = cyc + 1;
    #1;
    if (!r) begin
      sb_q.delete();
      hold_ct = '0;
      chk("rst_busy", {63'd0, bus.busy}, 64'd0);
      chk("rst_done", {63'd0, bus.done}, 64'd0);
      chk("rst_ct", bus.ct_out, 64'd0);
    end else if (bus.done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done ct_out=%h required=no done at cycle %0d",
                 bus.ct_out, cyc);
      end else begin
        e = sb_q.pop_front();
        chk("ct_out", bus.ct_out, e.ct);
        chk("latency", {32'd0, cyc}, {32'd0, e.due});
        chk("busy_at_done", {63'd0, bus.busy}, 64'd1);
        hold_ct = e.ct;
      end
    end else begin
      chk("ct_hold", bus.ct_out, hold_ct);
    end
  end

  // Issue one block from IDLE; done is due 13 edges after this negedge.
  task automatic start_block(input logic [63:0] k, input logic [63:0] p, input logic [63:0] c);
    @(negedge clk);
    bus.key_in = k;
    bus.pt_in  = p;
    bus.start  = 1'b1;
    sb_q.push_back(exp_t'{ct: c, due: cyc + 32'd13});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_drain(input int unsigned bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=%0d pending required=0 pending after %0d cycles",
               sb_q.size(), bound);
      sb_q.delete();
    end
  endtask

  initial begin
    int acc;
    bus.start  = 1'b0;
    bus.key_in = '0;
    bus.pt_in  = '0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    start_block(K1, P1, C1);
    wait_drain(40);
    start_block(K2, P2, C2);
    wait_drain(40);
    start_block(K3, P3, C3);
    wait_drain(40);
    start_block(K4, P4, C4);
    wait_drain(40);

    // Start pulse during RUN must be ignored.
    start_block(K1, P1, C1);
    repeat (3) @(negedge clk);
    bus.key_in = K2;
    bus.pt_in  = P2;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain(40);
    repeat (20) @(negedge clk);

    // Reset sampled at the edge that would complete round 6.
    start_block(K3, P3, C3);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    repeat (20) @(negedge clk);
    start_block(K4, P4, C4);
    wait_drain(40);

    // start held high: a block begins on every IDLE cycle.
    bus.key_in = K2;
    bus.pt_in  = P2;
    bus.start  = 1'b1;
    acc = 0;
    for (int i = 0; i < 60 && acc < 2; i++) begin
      if (!bus.busy) begin
        sb_q.push_back(exp_t'{ct: C2, due: cyc + 32'd13});
        acc++;
      end
      if (acc < 2) @(negedge clk);
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain(60);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
